fifo_stream_checker: RTL and testbench

// - Synthesisable, parametrised successor of the testbench FIFO monitor: passively observes one synchronous FIFO's ports.
// - Keeps a cycle-accurate shadow model (occupancy plus data queue) and checks every DUT output each cycle.
// - Counts passing and failing cycles, and latches sticky per-check error flags and the first failure.
// - Sits beside the FIFO in the test harness or in FPGA-based self-test; no path back into the DUT.

---
 rtl/fifo_chk_pkg.sv | 30 +++
 rtl/fifo_ref_model.sv | 89 ++++++++
 rtl/fifo_stream_checker.sv | 160 ++++++++++++++++
 tb/tb_fifo_stream_checker.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_chk_pkg.sv
// Shared types and helpers for the FIFO stream checker.
// Error codes index the sticky mismatch vector.
package fifo_chk_pkg;

  typedef enum logic [2:0] {
    E_DATA   = 3'd0,
    E_FULL   = 3'd1,
    E_EMPTY  = 3'd2,
    E_AFULL  = 3'd3,
    E_AEMPTY = 3'd4,
    E_ACK    = 3'd5,
    E_OVF    = 3'd6,
    E_UNF    = 3'd7
  } err_code_e;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    ARMED  = 2'd1,
    HALTED = 2'd2
  } chk_state_e;

  // Saturating increment; callers widen to 64 bits and narrow back.
  function automatic logic [63:0] sat_inc(
    input logic [63:0] v,
    input logic [63:0] max_v
  );
    return (v >= max_v) ? max_v : v + 64'd1;
  endfunction

endpackage

// File: rtl/fifo_ref_model.sv
// Cycle-accurate shadow of a synchronous FIFO.
// Produces occupancy and the registered responses the DUT should show.
module fifo_ref_model #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       wr_en,
  input  logic                       rd_en,
  input  logic [WIDTH-1:0]           data_in,
  output logic [$clog2(DEPTH+1)-1:0] cnt,
  output logic                       exp_ack,
  output logic                       exp_ovf,
  output logic                       exp_unf,
  output logic                       exp_dvld,
  output logic [WIDTH-1:0]           exp_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CB = $clog2(DEPTH+1);
  localparam logic [PW-1:0] P_LAST = PW'(DEPTH-1);
  localparam logic [PW-1:0] P_ONE  = PW'(1);
  localparam logic [CB-1:0] C_FULL = CB'(DEPTH);
  localparam logic [CB-1:0] C_ONE  = CB'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             is_full;
  logic             is_empty;
  logic             wr_acc;
  logic             rd_acc;

  // Pointers wrap at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == P_LAST) ? '0 : p + P_ONE;
  endfunction

  // Accept decisions from pre-edge occupancy.
  always_comb begin
    is_full  = (cnt == C_FULL);
    is_empty = (cnt == '0);
    wr_acc   = wr_en & ~is_full;
    rd_acc   = rd_en & ~is_empty;
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (en && wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers, occupancy and expected registered responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      exp_ack  <= 1'b0;
      exp_ovf  <= 1'b0;
      exp_unf  <= 1'b0;
      exp_dvld <= 1'b0;
      exp_data <= '0;
    end else if (en) begin
      exp_ack  <= wr_acc;
      exp_ovf  <= wr_en & is_full;
      exp_unf  <= rd_en & is_empty;
      exp_dvld <= rd_acc;
      if (wr_acc) begin
        wr_ptr <= nxt(wr_ptr);
      end
      if (rd_acc) begin
        rd_ptr   <= nxt(rd_ptr);
        exp_data <= mem[rd_ptr];
      end
      unique case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + C_ONE;
        2'b01:   cnt <= cnt - C_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/fifo_stream_checker.sv
// Passive FIFO checker: shadow model, per-cycle compare,
// saturating pass/error counters and first-failure capture.
module fifo_stream_checker
  import fifo_chk_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 8,
  parameter int CNT_W       = 32,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mon_en,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       wr_en,
  input  logic                       rd_en,
  input  logic [WIDTH-1:0]           data_out,
  input  logic                       wr_ack,
  input  logic                       overflow,
  input  logic                       underflow,
  input  logic                       full,
  input  logic                       almostfull,
  input  logic                       empty,
  input  logic                       almostempty,
  output logic [CNT_W-1:0]           pass_cnt,
  output logic [CNT_W-1:0]           err_cnt,
  output logic [7:0]                 err_sticky,
  output logic                       first_err_vld,
  output logic [2:0]                 first_err_code,
  output logic [CNT_W-1:0]           first_err_cyc,
  output logic [$clog2(DEPTH+1)-1:0] model_count,
  output logic                       halted
);

  localparam int CB = $clog2(DEPTH+1);
  localparam logic [CB-1:0] C_FULL = CB'(DEPTH);
  localparam logic [CB-1:0] C_AF   = CB'(DEPTH-1);
  localparam logic [CB-1:0] C_AE   = CB'(1);
  localparam logic [63:0] CNT_MAX =
    (64'd1 << CNT_W) - 64'd1;

  chk_state_e       state_q;
  chk_state_e       state_d;
  logic             run;
  logic             score;
  logic [CB-1:0]    cnt;
  logic             exp_ack;
  logic             exp_ovf;
  logic             exp_unf;
  logic             exp_dvld;
  logic [WIDTH-1:0] exp_data;
  logic [7:0]       mism;
  logic             any_err;
  err_code_e        low_code;
  logic [CNT_W-1:0] cycle_cnt;

  fifo_ref_model #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_model (
    .clk      (clk),
    .rst      (rst),
    .en       (run),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .data_in  (data_in),
    .cnt      (cnt),
    .exp_ack  (exp_ack),
    .exp_ovf  (exp_ovf),
    .exp_unf  (exp_unf),
    .exp_dvld (exp_dvld),
    .exp_data (exp_data)
  );

  assign model_count = cnt;

  // Compare DUT outputs against pre-edge model state.
  always_comb begin
    mism           = '0;
    mism[E_DATA]   = exp_dvld & (data_out != exp_data);
    mism[E_FULL]   = full        != (cnt == C_FULL);
    mism[E_EMPTY]  = empty       != (cnt == '0);
    mism[E_AFULL]  = almostfull  != (cnt == C_AF);
    mism[E_AEMPTY] = almostempty != (cnt == C_AE);
    mism[E_ACK]    = wr_ack    != exp_ack;
    mism[E_OVF]    = overflow  != exp_ovf;
    mism[E_UNF]    = underflow != exp_unf;
    any_err        = |mism;
  end

  // Lowest set mismatch bit names the failure.
  always_comb begin
    low_code = E_DATA;
    for (int i = 7; i >= 0; i--) begin
      if (mism[i]) begin
        low_code = err_code_e'(i[2:0]);
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SETTLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; HALTED is left only through reset.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SETTLE: state_d = ARMED;
      ARMED: begin
        if (STOP_ON_ERR && score && any_err) begin
          state_d = HALTED;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = SETTLE;
    endcase
  end

  // State decode: model tracking, scoring, halt flag.
  always_comb begin
    run    = (state_q != HALTED);
    score  = (state_q == ARMED) & mon_en;
    halted = (state_q == HALTED);
  end

  // Counters, sticky flags and first-failure capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt      <= '0;
      pass_cnt       <= '0;
      err_cnt        <= '0;
      err_sticky     <= '0;
      first_err_vld  <= 1'b0;
      first_err_code <= '0;
      first_err_cyc  <= '0;
    end else if (run) begin
      cycle_cnt <= CNT_W'(sat_inc(64'(cycle_cnt), CNT_MAX));
      if (score) begin
        if (any_err) begin
          err_cnt    <= CNT_W'(sat_inc(64'(err_cnt), CNT_MAX));
          err_sticky <= err_sticky | mism;
          if (!first_err_vld) begin
            first_err_vld  <= 1'b1;
            first_err_code <= low_code;
            first_err_cyc  <= cycle_cnt;
          end
        end else begin
          pass_cnt <= CNT_W'(sat_inc(64'(pass_cnt), CNT_MAX));
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_checker.sv
// Bench for fifo_stream_checker: the bench plays a behavioural FIFO,
// injects faults, and predicts each checker's scoring from a queue model.
module tb_fifo_stream_checker;

  localparam int W = 16;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         mon_en;
  logic [W-1:0] data_in;
  logic         wr_en;
  logic         rd_en;
  logic [W-1:0] data_out;
  logic         wr_ack;
  logic         overflow;
  logic         underflow;
  logic         full;
  logic         almostfull;
  logic         empty;
  logic         almostempty;

  logic [31:0] pc0, ec0, fy0, pc1, ec1, fy1;
  logic [3:0]  pc2, ec2, fy2;
  logic [7:0]  st0, st1, st2;
  logic        fv0, fv1, fv2;
  logic [2:0]  fc0, fc1, fc2;
  logic [3:0]  mc0, mc1, mc2;
  logic        h0, h1, h2;

  always #5 clk = ~clk;

  fifo_stream_checker #(
    .WIDTH(W), .DEPTH(D), .CNT_W(32), .STOP_ON_ERR(1'b0)
  ) u0 (
    .clk(clk), .rst(rst), .mon_en(mon_en), .data_in(data_in),
    .wr_en(wr_en), .rd_en(rd_en), .data_out(data_out),
    .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow),
    .full(full), .almostfull(almostfull), .empty(empty),
    .almostempty(almostempty), .pass_cnt(pc0), .err_cnt(ec0),
    .err_sticky(st0), .first_err_vld(fv0), .first_err_code(fc0),
    .first_err_cyc(fy0), .model_count(mc0), .halted(h0)
  );

  fifo_stream_checker #(
    .WIDTH(W), .DEPTH(D), .CNT_W(32), .STOP_ON_ERR(1'b1)
  ) u1 (
    .clk(clk), .rst(rst), .mon_en(mon_en), .data_in(data_in),
    .wr_en(wr_en), .rd_en(rd_en), .data_out(data_out),
    .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow),
    .full(full), .almostfull(almostfull), .empty(empty),
    .almostempty(almostempty), .pass_cnt(pc1), .err_cnt(ec1),
    .err_sticky(st1), .first_err_vld(fv1), .first_err_code(fc1),
    .first_err_cyc(fy1), .model_count(mc1), .halted(h1)
  );

  fifo_stream_checker #(
    .WIDTH(W), .DEPTH(D), .CNT_W(4), .STOP_ON_ERR(1'b0)
  ) u2 (
    .clk(clk), .rst(rst), .mon_en(mon_en), .data_in(data_in),
    .wr_en(wr_en), .rd_en(rd_en), .data_out(data_out),
    .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow),
    .full(full), .almostfull(almostfull), .empty(empty),
    .almostempty(almostempty), .pass_cnt(pc2), .err_cnt(ec2),
    .err_sticky(st2), .first_err_vld(fv2), .first_err_code(fc2),
    .first_err_cyc(fy2), .model_count(mc2), .halted(h2)
  );

  // Behavioural FIFO standing in for the monitored DUT.
  logic [W-1:0] q[$];
  logic [W-1:0] dout_r;
  bit           ack_r, ovf_r, unf_r, dvld_r;
  bit           inj_af_low, inj_data;

  // Expected checker state per instance (0 settle, 1 armed, 2 halted).
  longint      e_pass[3], e_err[3], e_fcyc[3], e_cyc[3], cmax[3];
  logic [7:0]  e_sticky[3];
  bit          e_fvld[3];
  int          e_fcode[3], e_state[3], e_mc[3];
  bit          stop_cfg[3];

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_inst(input int i, input logic [63:0] pc,
                          input logic [63:0] ec, input logic [7:0] st,
                          input logic fv, input logic [2:0] fc,
                          input logic [63:0] fy, input logic [3:0] mc,
                          input logic h);
    chk($sformatf("u%0d.pass_cnt", i), pc, e_pass[i]);
    chk($sformatf("u%0d.err_cnt", i), ec, e_err[i]);
    chk($sformatf("u%0d.err_sticky", i), 64'(st), 64'(e_sticky[i]));
    chk($sformatf("u%0d.first_vld", i), 64'(fv), 64'(e_fvld[i]));
    chk($sformatf("u%0d.first_code", i), 64'(fc), 64'(e_fcode[i]));
    chk($sformatf("u%0d.first_cyc", i), fy, e_fcyc[i]);
    chk($sformatf("u%0d.model_count", i), 64'(mc), 64'(e_mc[i]));
    chk($sformatf("u%0d.halted", i), 64'(h), 64'(e_state[i] == 2));
  endtask

  task automatic check_all();
    chk_inst(0, 64'(pc0), 64'(ec0), st0, fv0, fc0, 64'(fy0), mc0, h0);
    chk_inst(1, 64'(pc1), 64'(ec1), st1, fv1, fc1, 64'(fy1), mc1, h1);
    chk_inst(2, 64'(pc2), 64'(ec2), st2, fv2, fc2, 64'(fy2), mc2, h2);
  endtask

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic longint sat(input longint v, input longint m);
    return (v < m) ? v + 1 : m;
  endfunction

  task automatic do_reset(input int n);
    rst = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0; mon_en = 1'b0; data_in = '0;
    inj_af_low = 1'b0; inj_data = 1'b0;
    q.delete();
    dout_r = '0; ack_r = 1'b0; ovf_r = 1'b0; unf_r = 1'b0; dvld_r = 1'b0;
    data_out = '0; wr_ack = 1'b0; overflow = 1'b0; underflow = 1'b0;
    full = 1'b0; almostfull = 1'b0; empty = 1'b1; almostempty = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      e_pass[i] = 0; e_err[i] = 0; e_fcyc[i] = 0; e_cyc[i] = 0;
      e_sticky[i] = '0; e_fvld[i] = 1'b0; e_fcode[i] = 0;
      e_state[i] = 0; e_mc[i] = 0;
    end
    rst = 1'b0;
    check_all();
  endtask

  // One clock of FIFO traffic, scoring prediction and checks.
  task automatic step(input bit w, input bit r, input bit m,
                      input logic [W-1:0] din);
    int n;
    logic [7:0] vec;
    bit upd[3];
    n = q.size();
    wr_en = w; rd_en = r; mon_en = m; data_in = din;
    full        = (n == D);
    almostfull  = (n == D - 1) && !inj_af_low;
    empty       = (n == 0);
    almostempty = (n == 1);
    data_out    = inj_data ? (dout_r ^ 16'h00ff) : dout_r;
    wr_ack = ack_r; overflow = ovf_r; underflow = unf_r;
    vec = '0;
    if (inj_af_low && n == D - 1) vec[3] = 1'b1;
    if (inj_data && dvld_r) vec[0] = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      upd[i] = (e_state[i] != 2);
      if (e_state[i] == 2) continue;
      if (e_state[i] == 1 && m) begin
        if (vec != 0) begin
          e_err[i] = sat(e_err[i], cmax[i]);
          e_sticky[i] = e_sticky[i] | vec;
          if (!e_fvld[i]) begin
            e_fvld[i] = 1'b1;
            e_fcode[i] = lowest(vec);
            e_fcyc[i] = e_cyc[i];
          end
          if (stop_cfg[i]) e_state[i] = 2;
        end else begin
          e_pass[i] = sat(e_pass[i], cmax[i]);
        end
      end
      if (e_state[i] == 0) e_state[i] = 1;
      e_cyc[i] = sat(e_cyc[i], cmax[i]);
    end
    #1;
    ack_r  = w && (n != D);
    ovf_r  = w && (n == D);
    unf_r  = r && (n == 0);
    dvld_r = r && (n != 0);
    if (dvld_r) dout_r = q.pop_front();
    if (ack_r) q.push_back(din);
    for (int i = 0; i < 3; i++) if (upd[i]) e_mc[i] = q.size();
    check_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cmax[0] = 64'hFFFF_FFFF; cmax[1] = 64'hFFFF_FFFF; cmax[2] = 15;
    stop_cfg[0] = 1'b0; stop_cfg[1] = 1'b1; stop_cfg[2] = 1'b0;

    // Reset, settle cycle, then first scored idle cycle.
    do_reset(2);
    step(0, 0, 1, '0);
    step(0, 0, 1, '0);

    // Fill to full, then one overflowing write.
    for (int k = 1; k <= 9; k++) step(1, 0, 1, W'(k));
    step(0, 0, 1, '0);

    // Drain in order, then one underflowing read.
    for (int k = 0; k < 9; k++) step(0, 1, 1, '0);
    step(0, 0, 1, '0);

    // Steady cnt = 3 with simultaneous traffic wrapping pointers.
    for (int k = 0; k < 3; k++) step(1, 0, 1, W'(16'h100 + k));
    for (int k = 0; k < 20; k++) step(1, 1, 1, W'(16'h200 + k));
    for (int k = 0; k < 4; k++) step(0, 1, 1, '0);

    // Random traffic with intermittent scoring.
    for (int k = 0; k < 120; k++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0), W'($urandom));
    end

    // Corrupted read data: stop-on-error instance halts and freezes.
    do_reset(1);
    step(0, 0, 1, '0);
    step(1, 0, 1, 16'haaaa);
    step(1, 0, 1, 16'h5555);
    step(0, 1, 1, '0);
    inj_data = 1'b1;
    step(0, 0, 1, '0);
    inj_data = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'b1, W'($urandom));
    end

    // Reset mid-operation, then almostfull forced low at cnt = 7.
    do_reset(1);
    step(0, 0, 1, '0);
    step(0, 0, 0, '0);
    for (int k = 0; k < 7; k++) step(1, 0, 1, W'(16'h300 + k));
    inj_af_low = 1'b1;
    step(0, 0, 1, '0);
    inj_af_low = 1'b0;
    for (int k = 0; k < 5; k++) step(0, 1, 1, '0);

    // Long clean run: 4-bit counters saturate at 15.
    do_reset(1);
    for (int k = 0; k < 22; k++) step(0, 0, 1, '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
